// File: rtl/regfile_dump_tx.sv
// Debug dump transmitter: walks a register-file spare read port from FIRST_REG to LAST_REG
// and streams each register as an (index, value) beat over a valid/ready interface.
module regfile_dump_tx #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int FRAME_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_req,
    input  logic              dump_abort,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              dump_busy,
    output logic [FRAME_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   beat_idx_q, beat_idx_d;
    logic [DATA_W-1:0]   beat_data_q, beat_data_d;
    logic                beat_last_q, beat_last_d;
    logic                valid_q, valid_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic                handshake;

    assign handshake = valid_q & dump_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= FIRST_IDX;
            beat_idx_q  <= '0;
            beat_data_q <= '0;
            beat_last_q <= 1'b0;
            valid_q     <= 1'b0;
            frame_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            beat_idx_q  <= beat_idx_d;
            beat_data_q <= beat_data_d;
            beat_last_q <= beat_last_d;
            valid_q     <= valid_d;
            frame_q     <= frame_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        beat_idx_d  = beat_idx_q;
        beat_data_d = beat_data_q;
        beat_last_d = beat_last_q;
        valid_d     = valid_q;
        frame_d     = frame_q;

        case (state_q)
            S_IDLE: begin
                if (dump_req) begin
                    idx_d   = FIRST_IDX;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // No snapshot: the value is captured from the live read port in this cycle.
                if (dump_abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else begin
                    beat_data_d = rf_rdata;
                    beat_idx_d  = idx_q;
                    beat_last_d = (idx_q == LAST_IDX);
                    valid_d     = 1'b1;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                // Abort wins over a handshake on the same edge.
                if (dump_abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (handshake) begin
                    valid_d = 1'b0;
                    if (beat_last_q) begin
                        frame_d = frame_q + 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign rf_raddr   = idx_q;
    assign dump_valid = valid_q;
    assign dump_idx   = beat_idx_q;
    assign dump_data  = beat_data_q;
    assign dump_last  = beat_last_q;
    assign dump_busy  = (state_q != S_IDLE);
    assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Self-checking bench for regfile_dump_tx: a full-range instance and a 16..23 instance share one
// behavioural register file; each dump is checked beat by beat against the expected index walk.
module tb_regfile_dump_tx;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int FW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a_n, rst_b_n;
    logic          req_a, abort_a, ready_a, req_b, abort_b, ready_b;
    logic [AW-1:0] raddr_a, raddr_b, idx_a, idx_b;
    logic [DW-1:0] rdata_a, rdata_b, data_a, data_b;
    logic          valid_a, valid_b, last_a, last_b, busy_a, busy_b;
    logic [FW-1:0] frame_a, frame_b;

    logic [DW-1:0] rf [32];
    assign rdata_a = rf[raddr_a];
    assign rdata_b = rf[raddr_b];

    regfile_dump_tx #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(0), .LAST_REG(31), .FRAME_W(FW)) u_a (
        .clk(clk), .rst_n(rst_a_n), .dump_req(req_a), .dump_abort(abort_a),
        .rf_raddr(raddr_a), .rf_rdata(rdata_a), .dump_valid(valid_a), .dump_ready(ready_a),
        .dump_idx(idx_a), .dump_data(data_a), .dump_last(last_a), .dump_busy(busy_a),
        .frame_cnt(frame_a)
    );

    regfile_dump_tx #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(16), .LAST_REG(23), .FRAME_W(FW)) u_b (
        .clk(clk), .rst_n(rst_b_n), .dump_req(req_b), .dump_abort(abort_b),
        .rf_raddr(raddr_b), .rf_rdata(rdata_b), .dump_valid(valid_b), .dump_ready(ready_b),
        .dump_idx(idx_b), .dump_data(data_b), .dump_last(last_b), .dump_busy(busy_b),
        .frame_cnt(frame_b)
    );

    bit sel;
    wire          m_valid = sel ? valid_b : valid_a;
    wire          m_busy  = sel ? busy_b  : busy_a;
    wire          m_last  = sel ? last_b  : last_a;
    wire [AW-1:0] m_idx   = sel ? idx_b   : idx_a;
    wire [AW-1:0] m_raddr = sel ? raddr_b : raddr_a;
    wire [DW-1:0] m_data  = sel ? data_b  : data_a;
    wire [FW-1:0] m_frame = sel ? frame_b : frame_a;

    int checks = 0;
    int errors = 0;
    int exp_frame [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit b, input logic rq, input logic ab, input logic rd);
        if (b) begin
            req_b = rq; abort_b = ab; ready_b = rd;
        end else begin
            req_a = rq; abort_a = ab; ready_a = rd;
        end
    endtask

    // One dump on instance b. Expected data is the register-file content at the beat's read
    // cycle; the bench only writes registers that are already captured or not yet read.
    task automatic run_dump(input bit b, input int first, input int last,
                            input int stall_at, input int req_at, input int abort_at,
                            input int reset_at, input bit abort_with_req, input bit rnd);
        int exp_i, beats, cyc, prev_cyc, stall_cnt;
        bit fin, was_valid, prev_imm, imm, rq, rd;
        logic [DW-1:0] held;
        sel = b;
        @(negedge clk);
        drive(b, 1'b1, abort_with_req, 1'b0);
        @(negedge clk);
        drive(b, 1'b0, 1'b0, 1'b0);
        check("busy_rise", m_busy, 1);
        check("valid_low_in_read", m_valid, 0);
        check("raddr_first", m_raddr, first);
        exp_i = first; beats = 0; cyc = 0; prev_cyc = 0; stall_cnt = 0;
        fin = 0; was_valid = 0; prev_imm = 0; held = '0;
        for (int t = 0; t < 600 && !fin; t++) begin
            @(negedge clk);
            cyc++;
            rq = 0;
            if (m_valid) begin
                if (!was_valid) begin
                    if (beats == 0) check("first_beat_latency", cyc, 1);
                    else if (prev_imm) check("beat_spacing", cyc - prev_cyc, 2);
                    check("beat_idx", m_idx, exp_i);
                    check("beat_data", m_data, rf[exp_i]);
                    check("beat_last", m_last, exp_i == last);
                    held = m_data; prev_cyc = cyc; stall_cnt = 0; beats++;
                    was_valid = 1;
                    rq = (exp_i == req_at);
                    imm = 1;
                end else begin
                    check("hold_idx", m_idx, exp_i);
                    check("hold_data", m_data, held);
                    imm = 0;
                end
                check("raddr_send", m_raddr, exp_i);
                if (exp_i == reset_at) begin
                    if (b) rst_b_n = 1'b0; else rst_a_n = 1'b0;
                    #1;
                    check("rst_valid", m_valid, 0);
                    check("rst_busy", m_busy, 0);
                    check("rst_raddr", m_raddr, first);
                    check("rst_frame", m_frame, 0);
                    check("rst_idx", m_idx, 0);
                    check("rst_data", m_data, 0);
                    exp_frame[b] = 0;
                    drive(b, 1'b0, 1'b0, 1'b0);
                    @(negedge clk);
                    if (b) rst_b_n = 1'b1; else rst_a_n = 1'b1;
                    fin = 1;
                end else if (exp_i == abort_at) begin
                    drive(b, 1'b0, 1'b1, 1'b1);
                    @(negedge clk);
                    drive(b, 1'b0, 1'b0, 1'b0);
                    check("abort_busy", m_busy, 0);
                    check("abort_valid", m_valid, 0);
                    check("abort_frame", m_frame, exp_frame[b]);
                    fin = 1;
                end else begin
                    rd = 1;
                    if (exp_i == stall_at && stall_cnt < 5) begin
                        rd = 0;
                        stall_cnt++;
                        rf[exp_i] = $urandom;
                    end else if (rnd) begin
                        rd = ($urandom_range(0, 1) == 1);
                    end
                    if (rnd && exp_i < 31) rf[int'($urandom_range(exp_i + 1, 31))] = $urandom;
                    drive(b, rq, 1'b0, rd);
                    if (rd) begin
                        prev_imm = imm;
                        was_valid = 0;
                        if (exp_i == last) begin
                            @(negedge clk);
                            drive(b, 1'b0, 1'b0, 1'b0);
                            exp_frame[b] = (exp_frame[b] + 1) % (1 << FW);
                            check("done_busy", m_busy, 0);
                            check("done_valid", m_valid, 0);
                            check("done_frame", m_frame, exp_frame[b]);
                            check("beat_count", beats, last - first + 1);
                            fin = 1;
                        end else begin
                            exp_i++;
                        end
                    end
                end
            end else begin
                check("busy_in_read", m_busy, 1);
                check("raddr_read", m_raddr, exp_i);
                drive(b, 1'b0, 1'b0, $urandom_range(0, 1) == 1);
            end
        end
        check("dump_terminated", fin, 1);
    endtask

    initial begin
        rst_a_n = 0; rst_b_n = 0;
        req_a = 0; abort_a = 0; ready_a = 0;
        req_b = 0; abort_b = 0; ready_b = 0;
        exp_frame[0] = 0; exp_frame[1] = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
        repeat (3) @(negedge clk);
        rst_a_n = 1; rst_b_n = 1;
        @(negedge clk);
        check("t1_valid", valid_a, 0);
        check("t1_busy", busy_a, 0);
        check("t1_frame", frame_a, 0);
        check("t1_raddr", raddr_a, 0);
        check("t1_idx", idx_a, 0);
        check("t1_data", data_a, 0);
        check("t1_last", last_a, 0);
        check("t1_b_raddr", raddr_b, 16);
        check("t1_b_busy", busy_b, 0);

        // T2 full dump, T3 backpressure, T4 req while busy
        run_dump(0, 0, 31, -1, -1, -1, -1, 0, 0);
        run_dump(0, 0, 31, 7, -1, -1, -1, 0, 0);
        run_dump(0, 0, 31, -1, 12, -1, -1, 0, 0);

        // T5 abort on handshake edge, then restart
        run_dump(0, 0, 31, -1, -1, 10, -1, 0, 0);
        run_dump(0, 0, 31, -1, -1, -1, -1, 0, 1);

        // Abort in IDLE has no effect
        sel = 0;
        @(negedge clk); drive(0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); drive(0, 1'b0, 1'b0, 1'b0);
        check("idle_abort_busy", busy_a, 0);
        check("idle_abort_valid", valid_a, 0);
        check("idle_abort_frame", frame_a, exp_frame[0]);

        // Abort while in READ
        @(negedge clk); drive(0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(0, 1'b0, 1'b1, 1'b0);
        check("read_abort_busy_before", busy_a, 1);
        @(negedge clk); drive(0, 1'b0, 1'b0, 1'b0);
        check("read_abort_busy", busy_a, 0);
        check("read_abort_valid", valid_a, 0);
        check("read_abort_frame", frame_a, exp_frame[0]);

        // Abort together with req in IDLE still starts the dump
        run_dump(0, 0, 31, -1, -1, -1, -1, 1, 1);

        // T6 reset mid-dump on the 16..23 instance, re-run, then wrap the frame counter
        run_dump(1, 16, 23, -1, -1, -1, 19, 0, 0);
        run_dump(1, 16, 23, -1, -1, -1, -1, 0, 0);
        for (int k = 0; k < 255; k++) run_dump(1, 16, 23, -1, -1, -1, -1, 0, 1);
        check("frame_wrapped", frame_b, 0);
        check("frame_a_untouched", frame_a, exp_frame[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
